// File: rtl/rem_seq.sv
// Purpose: iterative signed remainder (truncating, result takes the sign of A) with DZF/SF/ZF flags.
// Latency: done pulses W+3 cycles after start is accepted (2 cycles when B == 0); one op per W+4 cycles.
// Backpressure: none queued; start is only sampled in IDLE and ignored while busy (incl. the done cycle).
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   start       - operation request, accepted only when idle
//   A, B        - signed W-bit dividend / divisor, captured on the accept cycle
//   busy        - high whenever an operation is in flight (state != IDLE)
//   done        - one-cycle pulse; R and flags are valid from this cycle onward
//   R           - signed remainder, sign-extended to RW bits
//   DZF/SF/ZF   - divide-by-zero, sign (R msb) and zero (R == 0, no DZF) flags
module rem_seq #(
    parameter int W  = 3,
    parameter int RW = W + 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  A,
    input  logic [W-1:0]  B,
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] R,
    output logic          DZF,
    output logic          SF,
    output logic          ZF
);

    localparam int CW = $clog2(W);

    localparam logic [2:0] st_idle = 3'd0;
    localparam logic [2:0] st_prep = 3'd1;
    localparam logic [2:0] st_iter = 3'd2;
    localparam logic [2:0] st_fix  = 3'd3;
    localparam logic [2:0] st_done = 3'd4;

    logic [2:0]    state;
    logic [W-1:0]  a_lat;
    logic [W-1:0]  b_lat;
    logic          sign_a;
    // Dividend magnitude shifts out of the MSB while quotient bits enter at
    // the LSB, so after the last step this register holds |A| / |B|.
    logic [W-1:0]  dvd_quo;
    logic [W-1:0]  b_mag;
    // Stored partial remainder is always < |B| <= 2^(W-1), so W bits suffice;
    // the working value during a step is the W+1-bit shifted copy below.
    logic [W-1:0]  prem;
    logic [CW-1:0] cnt;
    logic [RW-1:0] r_q;
    logic          dzf_q;
    logic          sf_q;
    logic          zf_q;

    logic [W:0]    shifted;
    logic          fits;
    logic [W-1:0]  diff;
    logic [RW-1:0] rem_ext;
    logic [RW-1:0] rem_signed;

    always_comb begin
        shifted    = {prem, dvd_quo[W-1]};
        fits       = (shifted >= {1'b0, b_mag});
        // Only consumed when fits, where the true difference is < |B| and
        // therefore exact in W bits.
        diff       = shifted[W-1:0] - b_mag;
        rem_ext    = RW'(prem);
        rem_signed = sign_a ? (RW'(0) - rem_ext) : rem_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= st_idle;
            a_lat   <= '0;
            b_lat   <= '0;
            sign_a  <= 1'b0;
            dvd_quo <= '0;
            b_mag   <= '0;
            prem    <= '0;
            cnt     <= '0;
            r_q     <= '0;
            dzf_q   <= 1'b0;
            sf_q    <= 1'b0;
            zf_q    <= 1'b0;
        end else begin
            case (state)
                st_idle: begin
                    if (start) begin
                        a_lat  <= A;
                        b_lat  <= B;
                        sign_a <= A[W-1];
                        state  <= st_prep;
                    end
                end
                st_prep: begin
                    // The most negative input negates to itself, whose
                    // unsigned reading is exactly 2^(W-1).
                    dvd_quo <= a_lat[W-1] ? (-a_lat) : a_lat;
                    b_mag   <= b_lat[W-1] ? (-b_lat) : b_lat;
                    prem    <= '0;
                    cnt     <= CW'(W - 1);
                    if (b_lat == '0) begin
                        r_q   <= '0;
                        dzf_q <= 1'b1;
                        sf_q  <= 1'b0;
                        zf_q  <= 1'b0;
                        state <= st_done;
                    end else begin
                        state <= st_iter;
                    end
                end
                st_iter: begin
                    prem    <= fits ? diff : shifted[W-1:0];
                    dvd_quo <= {dvd_quo[W-2:0], fits};
                    if (cnt == '0) begin
                        state <= st_fix;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                st_fix: begin
                    r_q   <= rem_signed;
                    dzf_q <= 1'b0;
                    sf_q  <= rem_signed[RW-1];
                    zf_q  <= (prem == '0);
                    state <= st_done;
                end
                st_done: begin
                    state <= st_idle;
                end
                default: begin
                    state <= st_idle;
                end
            endcase
        end
    end

    assign busy = (state != st_idle);
    assign done = (state == st_done);
    assign R    = r_q;
    assign DZF  = dzf_q;
    assign SF   = sf_q;
    assign ZF   = zf_q;

endmodule

// File: tb/tb_rem_seq.sv
// Purpose: randomized scoreboard bench for rem_seq against an arithmetic % reference.
// Latency: expected done cycle is carried in each scoreboard entry and checked.
// Backpressure: stimulus toggles start while busy to show it is ignored.
module tb_rem_seq;

    localparam int W   = 3;
    localparam int RW  = W + 2;
    localparam int LAT = W + 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          busy;
    logic          done;
    logic [RW-1:0] R;
    logic          DZF;
    logic          SF;
    logic          ZF;

    rem_seq #(.W(W), .RW(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .R     (R),
        .DZF   (DZF),
        .SF    (SF),
        .ZF    (ZF)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [RW-1:0] r;
        logic          dzf;
        logic          sf;
        logic          zf;
        int            cyc;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   busy_from = 1;
    int   busy_to   = 0;
    int   checks    = 0;
    int   errors    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: plain truncating % on the signed operand values.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        int ia, ib, r;
        sa = a;
        sb = b;
        ia = sa;
        ib = sb;
        e.cyc = 0;
        if (ib == 0) begin
            e.r = '0; e.dzf = 1'b1; e.sf = 1'b0; e.zf = 1'b0;
        end else begin
            r = ia % ib;
            e.r = r[RW-1:0]; e.dzf = 1'b0; e.sf = (r < 0); e.zf = (r == 0);
        end
        return e;
    endfunction

    // Monitor: pops on every done, otherwise checks outputs are held.
    exp_t got;
    always @(negedge clk) begin
        chk("busy", {31'b0, busy}, {31'b0, (cyc >= busy_from && cyc <= busy_to)});
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", {31'b0, done}, 32'd0);
            end else begin
                got = q.pop_front();
                chk("done_cycle", cyc, got.cyc);
                chk("R", {27'b0, R}, {27'b0, got.r});
                chk("DZF", {31'b0, DZF}, {31'b0, got.dzf});
                chk("SF", {31'b0, SF}, {31'b0, got.sf});
                chk("ZF", {31'b0, ZF}, {31'b0, got.zf});
                last = got;
            end
        end else begin
            chk("hold_R", {27'b0, R}, {27'b0, last.r});
            chk("hold_flags", {29'b0, DZF, SF, ZF}, {29'b0, last.dzf, last.sf, last.zf});
        end
    end

    // Drives the accept cycle (cycle 0) and returns the expected latency.
    task automatic begin_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        exp_t e;
        @(posedge clk); #1;
        A = a; B = b; start = 1'b1;
        e = model(a, b);
        lat = (b == '0) ? 2 : LAT;
        e.cyc = cyc + lat;
        q.push_back(e);
        busy_from = cyc + 1;
        busy_to   = cyc + lat;
    endtask

    // mode: 0 = start low while busy, 1 = start held high, 2 = random start
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
        int lat;
        begin_op(a, b, lat);
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk); #1;
            A = W'($urandom);
            B = W'($urandom);
            start = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            A = W'($urandom);
            B = W'($urandom);
        end
    endtask

    task automatic clear_expect();
        q.delete();
        last.r = '0; last.dzf = 1'b0; last.sf = 1'b0; last.zf = 1'b0; last.cyc = 0;
        busy_to = -1;
    endtask

    logic [2*W-1:0] pairs[$];
    logic [2*W-1:0] tmp;
    int             lat0;

    initial begin
        clear_expect();
        rst_n = 1'b1; start = 1'b0; A = '0; B = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_R", {27'b0, R}, 32'd0);
        chk("rst_flags", {29'b0, DZF, SF, ZF}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Directed cases
        run_op(3'b011, 3'b010, 0);
        run_op(3'b100, 3'b011, 0);
        run_op(3'b101, 3'b110, 0);
        run_op(3'b011, 3'b110, 0);
        run_op(3'b100, 3'b100, 0);
        run_op(3'b100, 3'b111, 0);
        idle(1);
        run_op(3'b011, 3'b000, 0);
        run_op(3'b000, 3'b000, 0);
        idle(3);

        // start held high with other operands while busy, then back-to-back
        run_op(3'b011, 3'b010, 1);
        run_op(3'b101, 3'b011, 1);
        run_op(3'b010, 3'b000, 1);
        idle(3);

        // Reset in cycle 3 of an operation
        begin_op(3'b100, 3'b011, lat0);
        repeat (3) begin @(posedge clk); #1; start = 1'b0; end
        rst_n = 1'b0;
        clear_expect();
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_R", {27'b0, R}, 32'd0);
        chk("midrst_flags", {29'b0, DZF, SF, ZF}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(3);
        run_op(3'b101, 3'b010, 0);

        // All 64 pairs in shuffled order with random start noise and gaps
        for (int i = 0; i < (1 << (2 * W)); i++) pairs.push_back((2 * W)'(i));
        for (int i = pairs.size() - 1; i > 0; i--) begin
            int j;
            j = $urandom_range(0, i);
            tmp = pairs[i]; pairs[i] = pairs[j]; pairs[j] = tmp;
        end
        foreach (pairs[i]) begin
            run_op(pairs[i][2*W-1:W], pairs[i][W-1:0], 2);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        idle(12);
        chk("pending_results", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
